axi4l_accel_periph: RTL and testbench

- Parameterised AXI4-Lite slave for the SoC. Replaces the simulation-only memory/peripheral model with a synthesizable equivalent.
- Contains a word-addressed SRAM region and a register window that drives a generic accelerator (SHA256 core first).
- Register window provides start/busy/done handshake, sticky done, interrupt, and SLVERR responses. Bad accesses get an error response; simulation never terminates.

---
 rtl/axi4l_accel_periph_if.sv | 34 +++
 rtl/axi4l_accel_periph.sv | 182 ++++++++++++++++++
 tb/tb_axi4l_accel_periph.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_accel_periph_if.sv
// axi4l_accel_periph_if: AXI4-Lite bus bundle between the SoC master and the memory/accelerator slave
//   aw*: write address channel   w*: write data channel   b*: write response channel
//   ar*: read address channel    r*: read data channel
//   modport slave  : used by axi4l_accel_periph
//   modport master : used by the bus master (CPU or testbench)
interface axi4l_accel_periph_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4l_accel_periph.sv
// axi4l_accel_periph: AXI4-Lite slave with word-addressed SRAM, a pass flag and an accelerator register window
//   clk, resetn  : clock, asynchronous active-low reset
//   mem_axi      : AXI4-Lite slave port (independent read and write FSMs)
//   acc_in       : accelerator input words, flattened, word 0 in the LSBs
//   acc_start    : one-cycle start pulse, raised in the write commit cycle
//   acc_busy     : accelerator running; blocks start and acc_in writes
//   acc_done     : one-cycle completion pulse; sets done_sticky
//   acc_out      : accelerator result words, flattened, word 0 in the LSBs
//   irq          : done_sticky & irq_en
//   tests_passed : sticky flag set by writing 1 to PASS_ADDR
module axi4l_accel_periph #(
   parameter int          MEM_WORDS   = 32768,
   parameter logic [31:0] PERIPH_BASE = 32'h3000_0000,
   parameter logic [31:0] PASS_ADDR   = 32'h2100_0000,
   parameter int          NUM_IN      = 16,
   parameter int          NUM_OUT     = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   axi4l_accel_periph_if.slave   mem_axi,
   output logic [32*NUM_IN-1:0]  acc_in,
   output logic                  acc_start,
   input  logic                  acc_busy,
   input  logic                  acc_done,
   input  logic [32*NUM_OUT-1:0] acc_out,
   output logic                  irq,
   output logic                  tests_passed
);
   localparam int          MW        = $clog2(MEM_WORDS);
   localparam int          IW        = $clog2(NUM_IN);
   localparam int          OW        = $clog2(NUM_OUT);
   localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);

   typedef enum logic [2:0] {REG_NONE, REG_MEM, REG_PASS, REG_CTRL, REG_STAT, REG_IN, REG_OUT} region_t;
   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACC, R_RESP} r_state_t;

   logic [31:0] mem [MEM_WORDS];
   logic [31:0] in_regs [NUM_IN];
   logic [31:0] out_w [NUM_OUT];
   w_state_t    w_state;
   r_state_t    r_state;
   logic        aw_got, w_got, aw_hs, w_hs, ar_hs, commit, w1c, w_err;
   logic [31:0] aw_addr, w_data, ar_addr, mem_q, r_data, status;
   logic [3:0]  w_strb;
   logic        done_sticky, irq_en;
   region_t     w_reg, r_reg;
   logic [IW-1:0] w_ii, r_ii;
   logic [OW-1:0] r_oi;

   function automatic region_t region(input logic [31:0] a);
      logic [5:0] w;
      w = a[7:2];
      if ({1'b0, a} < MEM_BYTES) return REG_MEM;
      if (a[31:2] == PASS_ADDR[31:2]) return REG_PASS;
      if (a[31:8] != PERIPH_BASE[31:8]) return REG_NONE;
      if (w == 6'd0) return REG_CTRL;
      if (w == 6'd1) return REG_STAT;
      if (w >= 6'd4 && (w - 6'd4) < 6'(NUM_IN)) return REG_IN;
      if (w[5] && {1'b0, w[4:0]} < 6'(NUM_OUT)) return REG_OUT;
      return REG_NONE;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
      return old;
   endfunction

   for (genvar i = 0; i < NUM_IN; i++) begin : g_in
      assign acc_in[32*i +: 32] = in_regs[i];
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign out_w[j] = acc_out[32*j +: 32];
   end

   assign aw_hs  = w_state == W_IDLE && mem_axi.awvalid && mem_axi.awready;
   assign w_hs   = w_state == W_IDLE && mem_axi.wvalid && mem_axi.wready;
   assign ar_hs  = r_state == R_IDLE && mem_axi.arvalid && mem_axi.arready;
   assign commit = w_state == W_IDLE && aw_got && w_got;
   assign w_reg  = region(aw_addr);
   assign r_reg  = region(ar_addr);
   assign w_ii   = IW'(aw_addr[7:2] - 6'd4);
   assign r_ii   = IW'(ar_addr[7:2] - 6'd4);
   assign r_oi   = ar_addr[OW+1:2];
   assign w1c    = commit && w_reg == REG_STAT && w_strb[0] && w_data[1];
   assign w_err  = w_reg == REG_NONE || w_reg == REG_OUT || (w_reg == REG_IN && acc_busy);
   assign status = {29'b0, irq_en, done_sticky, acc_busy};
   assign irq    = done_sticky & irq_en;
   assign r_data = r_reg == REG_MEM ? mem_q :
                   (r_reg == REG_CTRL || r_reg == REG_STAT) ? status :
                   r_reg == REG_IN ? in_regs[r_ii] :
                   r_reg == REG_OUT ? out_w[r_oi] : 32'h0;

   // The SRAM word is captured at the AR handshake so the array maps onto a
   // synchronous-read RAM; a write committing on that same edge is not seen.
   always_ff @(posedge clk) begin
      if (commit && w_reg == REG_MEM)
         for (int b = 0; b < 4; b++)
            if (w_strb[b]) mem[aw_addr[MW+1:2]][8*b +: 8] <= w_data[8*b +: 8];
      if (ar_hs) mem_q <= mem[mem_axi.araddr[MW+1:2]];
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         w_state         <= W_IDLE;
         aw_got          <= 1'b0;
         w_got           <= 1'b0;
         aw_addr         <= '0;
         w_data          <= '0;
         w_strb          <= '0;
         mem_axi.awready <= 1'b0;
         mem_axi.wready  <= 1'b0;
         mem_axi.bvalid  <= 1'b0;
         mem_axi.bresp   <= 2'b00;
         acc_start       <= 1'b0;
         done_sticky     <= 1'b0;
         irq_en          <= 1'b0;
         tests_passed    <= 1'b0;
         for (int i = 0; i < NUM_IN; i++) in_regs[i] <= '0;
      end else begin
         acc_start   <= 1'b0;
         // a done pulse coinciding with the W1C wins
         done_sticky <= acc_done | (done_sticky & ~w1c);
         if (w_state == W_IDLE) begin
            if (aw_hs) begin
               aw_got  <= 1'b1;
               aw_addr <= mem_axi.awaddr;
            end
            if (w_hs) begin
               w_got  <= 1'b1;
               w_data <= mem_axi.wdata;
               w_strb <= mem_axi.wstrb;
            end
            mem_axi.awready <= !(aw_got || aw_hs);
            mem_axi.wready  <= !(w_got || w_hs);
            if (commit) begin
               w_state        <= W_RESP;
               mem_axi.bvalid <= 1'b1;
               mem_axi.bresp  <= w_err ? 2'b10 : 2'b00;
               if (w_reg == REG_PASS && w_data == 32'd1) tests_passed <= 1'b1;
               if (w_reg == REG_CTRL && w_strb[0]) begin
                  acc_start <= w_data[0] && !acc_busy;
                  irq_en    <= w_data[1];
               end
               if (w_reg == REG_IN && !acc_busy) in_regs[w_ii] <= merge(in_regs[w_ii], w_data, w_strb);
            end
         end else if (mem_axi.bready) begin
            w_state         <= W_IDLE;
            aw_got          <= 1'b0;
            w_got           <= 1'b0;
            mem_axi.bvalid  <= 1'b0;
            mem_axi.awready <= 1'b1;
            mem_axi.wready  <= 1'b1;
         end
      end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_state         <= R_IDLE;
         ar_addr         <= '0;
         mem_axi.arready <= 1'b0;
         mem_axi.rvalid  <= 1'b0;
         mem_axi.rresp   <= 2'b00;
         mem_axi.rdata   <= '0;
      end else if (r_state == R_IDLE) begin
         mem_axi.arready <= !ar_hs;
         if (ar_hs) begin
            ar_addr <= mem_axi.araddr;
            r_state <= R_ACC;
         end
      end else if (r_state == R_ACC) begin
         mem_axi.rvalid <= 1'b1;
         mem_axi.rresp  <= r_reg == REG_NONE ? 2'b10 : 2'b00;
         mem_axi.rdata  <= r_data;
         r_state        <= R_RESP;
      end else if (mem_axi.rready) begin
         mem_axi.rvalid  <= 1'b0;
         mem_axi.arready <= 1'b1;
         r_state         <= R_IDLE;
      end
endmodule

// File: tb/tb_axi4l_accel_periph.sv
// tb_axi4l_accel_periph: directed self-checking bench for axi4l_accel_periph
module tb_axi4l_accel_periph;
   localparam logic [31:0] PB = 32'h3000_0000;
   localparam logic [31:0] PA = 32'h2100_0000;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic [511:0]   acc_in;
   logic           acc_start;
   logic           acc_busy = 1'b0;
   logic           acc_done = 1'b0;
   logic [255:0]   acc_out = '0;
   logic           irq;
   logic           tests_passed;
   int             n_cmp = 0;
   int             n_bad = 0;
   int             starts = 0;

   axi4l_accel_periph_if mem_axi();

   axi4l_accel_periph dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_axi      (mem_axi),
      .acc_in       (acc_in),
      .acc_start    (acc_start),
      .acc_busy     (acc_busy),
      .acc_done     (acc_done),
      .acc_out      (acc_out),
      .irq          (irq),
      .tests_passed (tests_passed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (acc_start) starts++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
      int t;
      bit aw_hs, w_hs;
      t = 0;
      @(negedge clk);
      mem_axi.awaddr = a;
      mem_axi.awvalid = 1'b1;
      mem_axi.wdata = d;
      mem_axi.wstrb = s;
      mem_axi.wvalid = 1'b1;
      while ((mem_axi.awvalid || mem_axi.wvalid) && t < 20) begin
         aw_hs = mem_axi.awvalid && mem_axi.awready;
         w_hs = mem_axi.wvalid && mem_axi.wready;
         @(negedge clk);
         if (aw_hs) mem_axi.awvalid = 1'b0;
         if (w_hs) mem_axi.wvalid = 1'b0;
         t++;
      end
      mem_axi.bready = 1'b1;
      while (!mem_axi.bvalid && t < 20) begin
         @(negedge clk);
         t++;
      end
      resp = mem_axi.bresp;
      n_cmp++;
      if (t >= 20) begin
         n_bad++;
         $display("FAIL write_timeout addr=%h: no bvalid, required response within 20 cycles", a);
         mem_axi.awvalid = 1'b0;
         mem_axi.wvalid = 1'b0;
      end
      @(negedge clk);
      mem_axi.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
      int t;
      bit hs;
      t = 0;
      @(negedge clk);
      mem_axi.araddr = a;
      mem_axi.arvalid = 1'b1;
      hs = 1'b0;
      while (!hs && t < 20) begin
         hs = mem_axi.arready;
         @(negedge clk);
         t++;
      end
      mem_axi.arvalid = 1'b0;
      lat = 1;
      while (!mem_axi.rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      d = mem_axi.rdata;
      resp = mem_axi.rresp;
      mem_axi.rready = 1'b1;
      n_cmp++;
      if (!hs || lat >= 20) begin
         n_bad++;
         $display("FAIL read_timeout addr=%h: no rvalid, required response within 20 cycles", a);
      end
      @(negedge clk);
      mem_axi.rready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({mem_axi.awready, mem_axi.wready, mem_axi.bvalid, mem_axi.arready, mem_axi.rvalid} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_handshake: got %b, required 00000", {mem_axi.awready, mem_axi.wready, mem_axi.bvalid, mem_axi.arready, mem_axi.rvalid});
      end
      n_cmp++;
      if ({mem_axi.bresp, mem_axi.rresp} !== 4'b0 || mem_axi.rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h, required 00 00 0", mem_axi.bresp, mem_axi.rresp, mem_axi.rdata);
      end
      n_cmp++;
      if (acc_in !== '0 || acc_start !== 1'b0 || irq !== 1'b0 || tests_passed !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: acc_in_nonzero=%b start=%b irq=%b passed=%b, required all 0", acc_in != '0, acc_start, irq, tests_passed);
      end
      resetn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({mem_axi.awready, mem_axi.wready, mem_axi.arready} !== 3'b111) begin
         n_bad++;
         $display("FAIL idle_ready: got %b, required 111", {mem_axi.awready, mem_axi.wready, mem_axi.arready});
      end
   endtask

   task automatic test_sram();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      axi_write(32'h100, 32'h0, 4'hF, r);
      axi_write(32'h100, 32'hDEADBEEF, 4'b0101, r);
      n_cmp++;
      if (r !== 2'b00) begin n_bad++; $display("FAIL sram_strobe_bresp: got %b, required 00", r); end
      axi_read(32'h100, d, r, lat);
      n_cmp++;
      if (d !== 32'h00AD00EF || r !== 2'b00) begin n_bad++; $display("FAIL sram_strobe_read: got %h/%b, required 00ad00ef/00", d, r); end
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL read_latency: got %0d, required 2", lat); end
      axi_write(32'h1FFFC, 32'h12345678, 4'hF, r);
      axi_read(32'h1FFFF, d, r, lat);
      n_cmp++;
      if (d !== 32'h12345678 || r !== 2'b00) begin n_bad++; $display("FAIL sram_last_word: got %h/%b, required 12345678/00", d, r); end
      axi_read(32'h20000, d, r, lat);
      n_cmp++;
      if (d !== 32'h0 || r !== 2'b10) begin n_bad++; $display("FAIL sram_past_end: got %h/%b, required 00000000/10", d, r); end
   endtask

   task automatic test_w_before_aw();
      int t, nb;
      logic [1:0] b;
      t = 0;
      nb = 0;
      b = 2'bxx;
      @(negedge clk);
      mem_axi.wdata = 32'h61626380;
      mem_axi.wstrb = 4'hF;
      mem_axi.wvalid = 1'b1;
      while (!mem_axi.wready && t < 20) begin @(negedge clk); t++; end
      @(negedge clk);
      mem_axi.wvalid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (mem_axi.wready !== 1'b0 || mem_axi.bvalid !== 1'b0 || mem_axi.awready !== 1'b1) begin
         n_bad++;
         $display("FAIL w_latched: wready=%b bvalid=%b awready=%b, required 0 0 1", mem_axi.wready, mem_axi.bvalid, mem_axi.awready);
      end
      mem_axi.awaddr = PB + 32'h10;
      mem_axi.awvalid = 1'b1;
      mem_axi.bready = 1'b1;
      @(negedge clk);
      mem_axi.awvalid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_axi.bvalid) begin nb++; b = mem_axi.bresp; end
      end
      mem_axi.bready = 1'b0;
      n_cmp++;
      if (nb !== 1 || b !== 2'b00) begin n_bad++; $display("FAIL w_first_resp: bvalid cycles=%0d bresp=%b, required 1 00", nb, b); end
      n_cmp++;
      if (acc_in[31:0] !== 32'h61626380) begin n_bad++; $display("FAIL w_first_data: got %h, required 61626380", acc_in[31:0]); end
   endtask

   task automatic test_ctrl();
      logic [1:0] r;
      logic [31:0] d;
      int s0, lat;
      axi_write(PB + 32'h14, 32'h11111111, 4'hF, r);
      s0 = starts;
      axi_write(PB, 32'h3, 4'hF, r);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (starts - s0 !== 1 || r !== 2'b00) begin n_bad++; $display("FAIL start_pulse: cycles=%0d bresp=%b, required 1 00", starts - s0, r); end
      acc_busy = 1'b1;
      s0 = starts;
      axi_write(PB, 32'h1, 4'hF, r);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (starts - s0 !== 0) begin n_bad++; $display("FAIL start_busy: cycles=%0d, required 0", starts - s0); end
      axi_write(PB + 32'h14, 32'hFFFFFFFF, 4'hF, r);
      n_cmp++;
      if (r !== 2'b10 || acc_in[63:32] !== 32'h11111111) begin n_bad++; $display("FAIL in_busy: bresp=%b word1=%h, required 10 11111111", r, acc_in[63:32]); end
      axi_read(PB + 32'h4, d, r, lat);
      n_cmp++;
      if (d[0] !== 1'b1 || d[31:3] !== 29'b0) begin n_bad++; $display("FAIL status_busy: got %h, required busy bit 1", d); end
      acc_busy = 1'b0;
      axi_write(PB + 32'h4C, 32'hA1B2C3D4, 4'b1100, r);
      axi_read(PB + 32'h4C, d, r, lat);
      n_cmp++;
      if (d !== 32'hA1B20000 || r !== 2'b00) begin n_bad++; $display("FAIL in_last_word: got %h/%b, required a1b20000/00", d, r); end
      axi_write(PB + 32'h50, 32'h1, 4'hF, r);
      n_cmp++;
      if (r !== 2'b10) begin n_bad++; $display("FAIL in_past_end: bresp=%b, required 10", r); end
   endtask

   task automatic test_irq();
      logic [1:0] r;
      logic [31:0] d;
      int t, lat;
      axi_write(PB, 32'h2, 4'hF, r);
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_idle: got %b, required 0", irq); end
      @(negedge clk);
      acc_done = 1'b1;
      @(negedge clk);
      acc_done = 1'b0;
      n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b, required 1", irq); end
      t = 0;
      while (!(mem_axi.awready && mem_axi.wready) && t < 20) begin @(negedge clk); t++; end
      mem_axi.awaddr = PB + 32'h4;
      mem_axi.wdata = 32'h2;
      mem_axi.wstrb = 4'hF;
      mem_axi.awvalid = 1'b1;
      mem_axi.wvalid = 1'b1;
      @(negedge clk);
      mem_axi.awvalid = 1'b0;
      mem_axi.wvalid = 1'b0;
      acc_done = 1'b1;
      @(negedge clk);
      acc_done = 1'b0;
      n_cmp++;
      if (mem_axi.bvalid !== 1'b1 || mem_axi.bresp !== 2'b00 || irq !== 1'b1) begin
         n_bad++;
         $display("FAIL set_wins: bvalid=%b bresp=%b irq=%b, required 1 00 1", mem_axi.bvalid, mem_axi.bresp, irq);
      end
      mem_axi.bready = 1'b1;
      @(negedge clk);
      mem_axi.bready = 1'b0;
      axi_read(PB, d, r, lat);
      n_cmp++;
      if (d !== 32'h6 || r !== 2'b00) begin n_bad++; $display("FAIL ctrl_read: got %h/%b, required 00000006/00", d, r); end
      axi_write(PB + 32'h4, 32'h2, 4'hF, r);
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b, required 0", irq); end
      axi_read(PB + 32'h4, d, r, lat);
      n_cmp++;
      if (d !== 32'h4) begin n_bad++; $display("FAIL status_read: got %h, required 00000004", d); end
   endtask

   task automatic test_errors();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      acc_out[31:0] = 32'hCAFEF00D;
      acc_out[255:224] = 32'h0BADC0DE;
      axi_read(32'h4000_0000, d, r, lat);
      n_cmp++;
      if (d !== 32'h0 || r !== 2'b10) begin n_bad++; $display("FAIL bad_read: got %h/%b, required 00000000/10", d, r); end
      axi_write(PB + 32'h80, 32'h5, 4'hF, r);
      n_cmp++;
      if (r !== 2'b10) begin n_bad++; $display("FAIL out_write: bresp=%b, required 10", r); end
      axi_read(PB + 32'h80, d, r, lat);
      n_cmp++;
      if (d !== 32'hCAFEF00D || r !== 2'b00) begin n_bad++; $display("FAIL out_read0: got %h/%b, required cafef00d/00", d, r); end
      axi_read(PB + 32'h9C, d, r, lat);
      n_cmp++;
      if (d !== 32'h0BADC0DE || r !== 2'b00) begin n_bad++; $display("FAIL out_read7: got %h/%b, required 0badc0de/00", d, r); end
      axi_read(PB + 32'hA0, d, r, lat);
      n_cmp++;
      if (r !== 2'b10) begin n_bad++; $display("FAIL out_past_end: rresp=%b, required 10", r); end
      axi_read(PB + 32'h8, d, r, lat);
      n_cmp++;
      if (r !== 2'b10 || d !== 32'h0) begin n_bad++; $display("FAIL hole_read: got %h/%b, required 00000000/10", d, r); end
      axi_write(PA, 32'h2, 4'hF, r);
      n_cmp++;
      if (tests_passed !== 1'b0 || r !== 2'b00) begin n_bad++; $display("FAIL pass_other: passed=%b bresp=%b, required 0 00", tests_passed, r); end
      axi_write(PA, 32'h1, 4'hF, r);
      n_cmp++;
      if (tests_passed !== 1'b1) begin n_bad++; $display("FAIL pass_set: got %b, required 1", tests_passed); end
      axi_read(PA, d, r, lat);
      n_cmp++;
      if (d !== 32'h0 || r !== 2'b00) begin n_bad++; $display("FAIL pass_read: got %h/%b, required 00000000/00", d, r); end
   endtask

   task automatic test_hold_and_reset();
      logic [1:0] b0, r;
      logic [31:0] d;
      int t, lat;
      t = 0;
      @(negedge clk);
      while (!(mem_axi.awready && mem_axi.wready) && t < 20) begin @(negedge clk); t++; end
      mem_axi.awaddr = PB + 32'h18;
      mem_axi.wdata = 32'hA5A5A5A5;
      mem_axi.wstrb = 4'hF;
      mem_axi.awvalid = 1'b1;
      mem_axi.wvalid = 1'b1;
      @(negedge clk);
      mem_axi.wvalid = 1'b0;
      mem_axi.awaddr = PB + 32'h1C;
      while (!mem_axi.bvalid && t < 20) begin @(negedge clk); t++; end
      b0 = mem_axi.bresp;
      n_cmp++;
      if (b0 !== 2'b00 || mem_axi.bvalid !== 1'b1) begin n_bad++; $display("FAIL hold_first: bvalid=%b bresp=%b, required 1 00", mem_axi.bvalid, b0); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (mem_axi.bvalid !== 1'b1 || mem_axi.bresp !== b0 || mem_axi.awready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_stable cycle %0d: bvalid=%b bresp=%b awready=%b, required 1 %b 0", i, mem_axi.bvalid, mem_axi.bresp, mem_axi.awready, b0);
         end
      end
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if (mem_axi.bvalid !== 1'b0 || acc_in !== '0) begin
         n_bad++;
         $display("FAIL async_reset: bvalid=%b acc_in_nonzero=%b, required 0 0", mem_axi.bvalid, acc_in != '0);
      end
      mem_axi.awvalid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      axi_write(PB + 32'h10, 32'h13579BDF, 4'hF, r);
      axi_read(PB + 32'h10, d, r, lat);
      n_cmp++;
      if (d !== 32'h13579BDF || r !== 2'b00) begin n_bad++; $display("FAIL after_reset: got %h/%b, required 13579bdf/00", d, r); end
   endtask

   initial begin
      mem_axi.awvalid = 1'b0;
      mem_axi.awaddr = '0;
      mem_axi.wvalid = 1'b0;
      mem_axi.wdata = '0;
      mem_axi.wstrb = '0;
      mem_axi.bready = 1'b0;
      mem_axi.arvalid = 1'b0;
      mem_axi.araddr = '0;
      mem_axi.rready = 1'b0;
      test_reset();
      test_sram();
      test_w_before_aw();
      test_ctrl();
      test_irq();
      test_errors();
      test_hold_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
